// File: rtl/rv_trace_buffer.sv
// rtl/rv_trace_buffer.sv - retirement trace recorder with PC trigger and freeze-then-drain readout
module rv_trace_buffer #(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int PIPE_STAGES      = 3,
  parameter int DEPTH            = 16,
  parameter int CNT_BITS         = $clog2(DEPTH) + 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  input  logic [31:0]                 i_instr,
  input  logic                        i_reg_write,
  input  logic                        i_mem_write,
  input  logic                        i_mem_read,
  input  logic [PIPE_STAGES-1:0]      i_flush,
  input  logic [31:0]                 i_mem_addr,
  input  logic [31:0]                 i_mem_data,
  input  logic [31:0]                 i_reg_data,
  input  logic                        i_arm,
  input  logic                        i_stop,
  input  logic                        i_trig_en,
  input  logic [IADDR_SPACE_BITS-1:0] i_trig_pc,
  input  logic [CNT_BITS-1:0]         i_post_count,
  input  logic                        i_pop,
  output logic [1:0]                  o_state,
  output logic [CNT_BITS-1:0]         o_count,
  output logic                        o_empty,
  output logic                        o_wrapped,
  output logic                        o_triggered,
  output logic [IADDR_SPACE_BITS-1:0] o_rd_pc,
  output logic [31:0]                 o_rd_instr,
  output logic [31:0]                 o_rd_data,
  output logic [31:0]                 o_rd_addr,
  output logic [31:0]                 o_rd_mdata,
  output logic [2:0]                  o_rd_flags
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LAST     = PIPE_STAGES - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_POST   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Pipeline shadow of the core: one slot per stage, flags packed {reg_write, mem_write, mem_read}
  logic [IADDR_SPACE_BITS-1:0] pipe_pc_q    [PIPE_STAGES];
  logic [IADDR_SPACE_BITS-1:0] pipe_pc_d    [PIPE_STAGES];
  logic [31:0]                 pipe_instr_q [PIPE_STAGES];
  logic [31:0]                 pipe_instr_d [PIPE_STAGES];
  logic [2:0]                  pipe_flags_q [PIPE_STAGES];
  logic [2:0]                  pipe_flags_d [PIPE_STAGES];
  logic [31:0]                 last_addr_q, last_addr_d;
  logic [31:0]                 last_mdata_q, last_mdata_d;

  // Control state
  state_e                      state_q, state_d;
  logic [PTR_BITS-1:0]         wptr_q, wptr_d;
  logic [PTR_BITS-1:0]         rptr_q, rptr_d;
  logic [CNT_BITS-1:0]         count_q, count_d;
  logic [CNT_BITS-1:0]         post_q, post_d;
  logic                        wrapped_q, wrapped_d;
  logic                        triggered_q, triggered_d;

  // Trace storage (contents need no reset; validity is tracked by count/pointers)
  logic [IADDR_SPACE_BITS-1:0] mem_pc_q    [DEPTH];
  logic [31:0]                 mem_instr_q [DEPTH];
  logic [31:0]                 mem_data_q  [DEPTH];
  logic [31:0]                 mem_addr_q  [DEPTH];
  logic [31:0]                 mem_mdata_q [DEPTH];
  logic [2:0]                  mem_flags_q [DEPTH];

  logic                        mem_we;
  logic                        retire;
  logic                        trig_hit;
  logic [31:0]                 wr_data;

  // Stage advance: each stage takes its predecessor unless its flush bit forces a bubble
  always_comb begin
    pipe_pc_d[0]    = i_flush[0] ? '0 : i_pc;
    pipe_instr_d[0] = i_flush[0] ? '0 : i_instr;
    pipe_flags_d[0] = i_flush[0] ? '0 : {i_reg_write, i_mem_write, i_mem_read};
    for (int k = 1; k < PIPE_STAGES; k++) begin
      pipe_pc_d[k]    = i_flush[k] ? '0 : pipe_pc_q[k-1];
      pipe_instr_d[k] = i_flush[k] ? '0 : pipe_instr_q[k-1];
      pipe_flags_d[k] = i_flush[k] ? '0 : pipe_flags_q[k-1];
    end
    last_addr_d  = i_flush[LAST] ? '0 : i_mem_addr;
    last_mdata_d = i_flush[LAST] ? '0 : i_mem_data;
  end

  // Pipeline registers; reset empties every stage to a bubble
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        pipe_pc_q[k]    <= '0;
        pipe_instr_q[k] <= '0;
        pipe_flags_q[k] <= '0;
      end
      last_addr_q  <= '0;
      last_mdata_q <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        pipe_pc_q[k]    <= pipe_pc_d[k];
        pipe_instr_q[k] <= pipe_instr_d[k];
        pipe_flags_q[k] <= pipe_flags_d[k];
      end
      last_addr_q  <= last_addr_d;
      last_mdata_q <= last_mdata_d;
    end
  end

  assign retire   = (pipe_instr_q[LAST] != '0);
  assign trig_hit = i_trig_en && retire && (pipe_pc_q[LAST] == i_trig_pc);
  assign wr_data  = pipe_flags_q[LAST][2] ? i_reg_data : '0;

  // Recorder FSM: arm beats stop, stop beats trigger/post countdown, recording happens underneath
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    post_d      = post_q;
    wrapped_d   = wrapped_q;
    triggered_d = triggered_q;
    mem_we      = 1'b0;
    if (i_arm) begin
      state_d     = ST_RECORD;
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      post_d      = '0;
      wrapped_d   = 1'b0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_RECORD, ST_POST: begin
          if (retire) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + PTR_BITS'(1);
            if (count_q != CNT_BITS'(DEPTH)) begin
              count_d = count_q + CNT_BITS'(1);
            end else begin
              // Full: the oldest entry is overwritten, so the read side slides forward
              rptr_d    = rptr_q + PTR_BITS'(1);
              wrapped_d = 1'b1;
            end
          end
          if (i_stop) begin
            state_d = ST_DONE;
          end else if (state_q == ST_RECORD && trig_hit) begin
            triggered_d = 1'b1;
            post_d      = i_post_count;
            state_d     = (i_post_count == '0) ? ST_DONE : ST_POST;
          end else if (state_q == ST_POST && retire) begin
            post_d = post_q - CNT_BITS'(1);
            if (post_q == CNT_BITS'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_pop && count_q != '0) begin
            rptr_d  = rptr_q + PTR_BITS'(1);
            count_d = count_q - CNT_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      post_q      <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      wrapped_q   <= wrapped_d;
      triggered_q <= triggered_d;
    end
  end

  // Trace storage write of the retiring record
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_pc_q[wptr_q]    <= pipe_pc_q[LAST];
      mem_instr_q[wptr_q] <= pipe_instr_q[LAST];
      mem_data_q[wptr_q]  <= wr_data;
      mem_addr_q[wptr_q]  <= last_addr_q;
      mem_mdata_q[wptr_q] <= last_mdata_q;
      mem_flags_q[wptr_q] <= pipe_flags_q[LAST];
    end
  end

  assign o_state     = state_q;
  assign o_count     = count_q;
  assign o_empty     = (count_q == '0);
  assign o_wrapped   = wrapped_q;
  assign o_triggered = triggered_q;

  // Oldest-entry readout, forced to zero when nothing valid is held
  always_comb begin
    o_rd_pc    = '0;
    o_rd_instr = '0;
    o_rd_data  = '0;
    o_rd_addr  = '0;
    o_rd_mdata = '0;
    o_rd_flags = '0;
    if (count_q != '0) begin
      o_rd_pc    = mem_pc_q[rptr_q];
      o_rd_instr = mem_instr_q[rptr_q];
      o_rd_data  = mem_data_q[rptr_q];
      o_rd_addr  = mem_addr_q[rptr_q];
      o_rd_mdata = mem_mdata_q[rptr_q];
      o_rd_flags = mem_flags_q[rptr_q];
    end
  end

endmodule

// File: tb/tb_rv_trace_buffer.sv
// tb/tb_rv_trace_buffer.sv - scoreboard bench for rv_trace_buffer
module tb_rv_trace_buffer;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_reg_write, i_mem_write, i_mem_read;
  logic [2:0]  i_flush;
  logic [31:0] i_mem_addr, i_mem_data, i_reg_data;
  logic        i_arm, i_stop, i_trig_en;
  logic [31:0] i_trig_pc;
  logic [4:0]  i_post_count;
  logic        i_pop;
  logic [1:0]  o_state;
  logic [4:0]  o_count;
  logic        o_empty, o_wrapped, o_triggered;
  logic [31:0] o_rd_pc, o_rd_instr, o_rd_data, o_rd_addr, o_rd_mdata;
  logic [2:0]  o_rd_flags;

  rv_trace_buffer #(.IADDR_SPACE_BITS(32), .PIPE_STAGES(3), .DEPTH(16), .CNT_BITS(5)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pc(i_pc), .i_instr(i_instr),
    .i_reg_write(i_reg_write), .i_mem_write(i_mem_write), .i_mem_read(i_mem_read),
    .i_flush(i_flush), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .i_reg_data(i_reg_data), .i_arm(i_arm), .i_stop(i_stop), .i_trig_en(i_trig_en),
    .i_trig_pc(i_trig_pc), .i_post_count(i_post_count), .i_pop(i_pop),
    .o_state(o_state), .o_count(o_count), .o_empty(o_empty), .o_wrapped(o_wrapped),
    .o_triggered(o_triggered), .o_rd_pc(o_rd_pc), .o_rd_instr(o_rd_instr),
    .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr), .o_rd_mdata(o_rd_mdata),
    .o_rd_flags(o_rd_flags)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] mdata;
    logic [2:0]  flags;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] p1 = 0, p2 = 0, p3 = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h0000_0093 | (pc << 12);
  endfunction
  function automatic logic [2:0] flags_of(input logic [31:0] pc);
    return {~pc[3], pc[2], pc[3] & ~pc[2]};
  endfunction
  function automatic logic [31:0] addr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] mdata_of(input logic [31:0] pc);
    return pc + 32'h1234_0000;
  endfunction
  function automatic exp_t exp_of(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    e.flags = flags_of(pc);
    e.data  = e.flags[2] ? ~pc : 32'h0;
    e.addr  = addr_of(pc);
    e.mdata = mdata_of(pc);
    return e;
  endfunction
  function automatic exp_t exp_zero();
    exp_t e;
    e.pc = 0; e.instr = 0; e.data = 0; e.addr = 0; e.mdata = 0; e.flags = 0;
    return e;
  endfunction

  // One clock of stimulus; memory/reg data track the PCs two and three cycles back
  task automatic cyc(input bit v, input logic [31:0] pc);
    i_pc       = v ? pc : 32'h0;
    i_instr    = v ? instr_of(pc) : 32'h0;
    {i_reg_write, i_mem_write, i_mem_read} = v ? flags_of(pc) : 3'b000;
    i_mem_addr = addr_of(p2);
    i_mem_data = mdata_of(p2);
    i_reg_data = ~p3;
    @(posedge i_clk);
    #1;
    p3 = p2;
    p2 = p1;
    p1 = pc;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_expect(input exp_t e);
    exp_q.push_back(e);
    i_pop = 1'b1;
    cyc(1'b0, 32'h0);
    i_pop = 1'b0;
  endtask

  // Monitor: every popped cycle presents the oldest entry, compared against the scoreboard
  always @(negedge i_clk) begin
    if (i_pop) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got pc 0x%08h with no expectation queued", o_rd_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_rd_pc !== mon_e.pc || o_rd_instr !== mon_e.instr || o_rd_data !== mon_e.data ||
            o_rd_addr !== mon_e.addr || o_rd_mdata !== mon_e.mdata || o_rd_flags !== mon_e.flags) begin
          n_err++;
          $display("FAIL pop_entry: got pc=%08h ins=%08h d=%08h a=%08h m=%08h f=%0b expected pc=%08h ins=%08h d=%08h a=%08h m=%08h f=%0b",
                   o_rd_pc, o_rd_instr, o_rd_data, o_rd_addr, o_rd_mdata, o_rd_flags,
                   mon_e.pc, mon_e.instr, mon_e.data, mon_e.addr, mon_e.mdata, mon_e.flags);
        end
      end
    end
  end

  initial begin
    i_reset_n = 1'b0; i_flush = 0; i_arm = 0; i_stop = 0; i_trig_en = 0;
    i_trig_pc = 0; i_post_count = 0; i_pop = 0;
    bubbles(2);
    check("reset_state", 32'(o_state), 0);
    check("reset_count", 32'(o_count), 0);
    check("reset_empty", 32'(o_empty), 1);
    check("reset_wrapped", 32'(o_wrapped), 0);
    check("reset_triggered", 32'(o_triggered), 0);
    check("reset_rd_pc", o_rd_pc, 0);
    i_reset_n = 1'b1;

    // Single instruction retire and drain
    i_arm = 1; cyc(1'b0, 0); i_arm = 0;
    check("arm_state", 32'(o_state), 1);
    cyc(1'b1, 32'h100);
    bubbles(4);
    check("single_count", 32'(o_count), 1);
    i_stop = 1; cyc(1'b0, 0); i_stop = 0;
    check("stop_state", 32'(o_state), 3);
    pop_expect(exp_of(32'h100));
    check("single_empty", 32'(o_empty), 1);
    pop_expect(exp_zero());
    check("empty_pop_count", 32'(o_count), 0);
    check("empty_pop_state", 32'(o_state), 3);

    // Wraparound: 20 retires into 16 entries
    i_arm = 1; cyc(1'b0, 0); i_arm = 0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(i * 4));
    bubbles(4);
    i_stop = 1; cyc(1'b0, 0); i_stop = 0;
    check("wrap_count", 32'(o_count), 16);
    check("wrap_flag", 32'(o_wrapped), 1);
    for (int i = 0; i < 16; i++) pop_expect(exp_of(32'h10 + 32'(i * 4)));
    check("wrap_drained", 32'(o_empty), 1);

    // Trigger with post window of 3
    i_trig_en = 1; i_trig_pc = 32'h200; i_post_count = 3;
    i_arm = 1; cyc(1'b0, 0); i_arm = 0;
    for (int i = 0; i < 13; i++) cyc(1'b1, 32'h1F0 + 32'(i * 4));
    bubbles(4);
    check("trig_state", 32'(o_state), 3);
    check("trig_flag", 32'(o_triggered), 1);
    check("trig_count", 32'(o_count), 8);
    check("trig_wrapped", 32'(o_wrapped), 0);
    for (int i = 0; i < 8; i++) pop_expect(exp_of(32'h1F0 + 32'(i * 4)));
    i_trig_en = 0;

    // Flush of stage 1 kills the instruction entering it
    i_arm = 1; cyc(1'b0, 0); i_arm = 0;
    cyc(1'b1, 32'h2FC);
    cyc(1'b1, 32'h300);
    i_flush = 3'b010; cyc(1'b1, 32'h304); i_flush = 0;
    bubbles(4);
    check("flush_count", 32'(o_count), 2);
    i_stop = 1; cyc(1'b0, 0); i_stop = 0;
    pop_expect(exp_of(32'h2FC));
    pop_expect(exp_of(32'h304));

    // Reset during POST
    i_trig_en = 1; i_trig_pc = 32'h404; i_post_count = 10;
    i_arm = 1; cyc(1'b0, 0); i_arm = 0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h400 + 32'(i * 4));
    bubbles(4);
    check("post_state", 32'(o_state), 2);
    check("post_count", 32'(o_count), 5);
    i_reset_n = 1'b0;
    #1;
    check("rst_state", 32'(o_state), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_rd_pc", o_rd_pc, 0);
    check("rst_rd_data", o_rd_data, 0);
    cyc(1'b0, 0);
    i_reset_n = 1'b1;
    i_trig_en = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h480 + 32'(i * 4));
    i_stop = 1; bubbles(4); i_stop = 0;
    check("idle_no_record", 32'(o_count), 0);
    check("idle_stop_state", 32'(o_state), 0);

    // Pop during RECORD is ignored
    i_arm = 1; cyc(1'b0, 0); i_arm = 0;
    cyc(1'b1, 32'h500);
    bubbles(4);
    pop_expect(exp_of(32'h500));
    check("rec_pop_count", 32'(o_count), 1);
    check("rec_pop_state", 32'(o_state), 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
